// File: rtl/mem_access.sv
// mem_access: memory-access stage of the multicycle core.
// Captures a decoded load/store on a one-cycle 'enabled' pulse, runs one
// word-wide req/ack transaction on the data bus, aligns and extends load
// data, and presents 'result' with a 'completed' flag to write-back.
// Non-memory instructions pass alu_result through with one cycle latency.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses (adds the 'misaligned' output).
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result,
    output logic        completed
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        done_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] result_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned_q;
    logic        misalign_d;

    // Alignment check of the incoming request (funct3[1:0] gives the size).
    always_comb begin
        case (funct3[1:0])
            2'b00:   misalign_d = 1'b0;
            2'b01:   misalign_d = addr[0];
            default: misalign_d = |addr[1:0];
        endcase
    end

    assign misaligned = misaligned_q;
`endif

    // Store lane encoding from the incoming request; undefined sizes act as word.
    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = store_data;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the latched request.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_d = funct3_q[2] ? {24'b0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_d = funct3_q[2] ? {16'b0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            default: load_d = mem_rdata;
        endcase
    end

    // Control FSM with registered bus, result and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            mem_wstrb_q  <= 4'b0;
            result_q     <= 32'b0;
            done_q       <= 1'b0;
            funct3_q     <= 3'b0;
            off_q        <= 2'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (enabled) begin
                        done_q   <= 1'b0;
                        funct3_q <= funct3;
                        off_q    <= addr[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
                        misaligned_q <= 1'b0;
`endif
                        if (is_load || is_store) begin
                            result_q <= 32'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                            if (misalign_d) begin
                                // Trapped access never reaches the bus.
                                misaligned_q <= 1'b1;
                                done_q       <= 1'b1;
                                state_q      <= DONE;
                            end else
`endif
                            begin
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= is_store;
                                mem_addr_q  <= {addr[31:2], 2'b00};
                                mem_wdata_q <= is_store ? wdata_d : 32'b0;
                                mem_wstrb_q <= is_store ? wstrb_d : 4'b0;
                                state_q     <= BUS;
                            end
                        end else begin
                            result_q <= alu_result;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            result_q <= load_d;
                        end
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign result    = result_q;
    // A fresh start pulse hides the previous completion in its own cycle.
    assign completed = done_q & ~enabled;

endmodule
